// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the signals around the shared RAM port: the bus-controller data
//   requester, the two per-core instruction-fetch requesters and the RAM side.
//   master : arbiter view (drives waits, loads, RAM controls, mem_error)
//   slave  : environment view (drives requests, addresses, RAM responses)
// Signals
//   bdREN/bdWEN/bdaddr/bdstore  data request         bdwait/bdload   data response
//   iREN/iaddr                  per-core fetch req   iwait/iload     per-core response
//   ramREN/ramWEN/ramaddr/ramstore  RAM command      ramload/ramstate  RAM response
//   mem_error                   granted access saw ramstate ERROR
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32
);
   logic                         bdREN;
   logic                         bdWEN;
   logic [ADDR_W-1:0]            bdaddr;
   logic [ADDR_W-1:0]            bdstore;
   logic                         bdwait;
   logic [ADDR_W-1:0]            bdload;
   logic [1:0]                   iREN;
   logic [1:0][ADDR_W-1:0]       iaddr;
   logic [1:0]                   iwait;
   logic [1:0][ADDR_W-1:0]       iload;
   logic                         ramREN;
   logic                         ramWEN;
   logic [ADDR_W-1:0]            ramaddr;
   logic [ADDR_W-1:0]            ramstore;
   logic [ADDR_W-1:0]            ramload;
   logic [1:0]                   ramstate;
   logic                         mem_error;

   modport master (
      input  bdREN, bdWEN, bdaddr, bdstore, iREN, iaddr, ramload, ramstate,
      output bdwait, bdload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, mem_error
   );

   modport slave (
      output bdREN, bdWEN, bdaddr, bdstore, iREN, iaddr, ramload, ramstate,
      input  bdwait, bdload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, mem_error
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one RAM port between the coherence-bus data path and two
//   instruction-fetch requesters. One grant at a time, held until RAM reports
//   ACCESS (or the granted requester withdraws). Data has priority, a
//   starvation counter forces an instruction grant after STARVE_LIMIT data
//   completions with fetches pending, and the two fetch ports alternate.
// Ports
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   mem_port_arbiter_if.master (requests, responses, RAM command/response)
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic                CLK,
   input  logic                nRST,
   mem_port_arbiter_if.master  bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DATA  = 2'd1;
   localparam logic [1:0] INSTR = 2'd2;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [1:0] state_q, state_d;
   logic       g_q, g_d;
   logic       rr_ptr_q, rr_ptr_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;

   logic                    ram_ren, ram_wen, mem_err, bd_wait;
   logic [ADDR_W-1:0]       ram_addr, ram_store, bd_load;
   logic [1:0]              i_wait;
   logic [1:0][ADDR_W-1:0]  i_load;
   logic                    pick;

   // Both fetch ports pending: round-robin pointer decides; else the lone requester.
   assign pick = (&bus.iREN) ? rr_ptr_q : bus.iREN[1];

   always_comb begin
      state_d      = state_q;
      g_d          = g_q;
      rr_ptr_d     = rr_ptr_q;
      starve_cnt_d = starve_cnt_q;
      ram_ren      = 1'b0;
      ram_wen      = 1'b0;
      ram_addr     = '0;
      ram_store    = '0;
      mem_err      = 1'b0;
      bd_wait      = 1'b1;
      bd_load      = '0;
      i_wait       = 2'b11;
      i_load       = '0;

      case (state_q)
         DATA: begin
            if (!(bus.bdREN || bus.bdWEN)) begin
               // Withdrawn: release the port without a completion pulse.
               state_d = IDLE;
            end else begin
               ram_wen   = bus.bdWEN;
               ram_ren   = bus.bdREN & ~bus.bdWEN;  // a write wins over a read
               ram_addr  = bus.bdaddr;
               ram_store = bus.bdstore;
               if (bus.ramstate == RAM_ERROR) begin
                  mem_err = 1'b1;
               end else if (bus.ramstate == RAM_ACCESS) begin
                  bd_wait = 1'b0;
                  bd_load = bus.ramload;
                  state_d = IDLE;
                  if ((|bus.iREN) && (starve_cnt_q != LIMIT)) begin
                     starve_cnt_d = starve_cnt_q + 4'd1;
                  end
               end
            end
         end

         INSTR: begin
            if (!bus.iREN[g_q]) begin
               state_d = IDLE;
            end else begin
               ram_ren  = 1'b1;
               ram_addr = bus.iaddr[g_q];
               if (bus.ramstate == RAM_ERROR) begin
                  mem_err = 1'b1;
               end else if (bus.ramstate == RAM_ACCESS) begin
                  i_wait[g_q]  = 1'b0;
                  i_load[g_q]  = bus.ramload;
                  rr_ptr_d     = ~g_q;
                  starve_cnt_d = '0;
                  state_d      = IDLE;
               end
            end
         end

         default: begin
            // IDLE (and any unreachable encoding): choose the next owner.
            if (!(|bus.iREN)) begin
               starve_cnt_d = '0;
            end
            if ((starve_cnt_q == LIMIT) && (|bus.iREN)) begin
               state_d = INSTR;
               g_d     = pick;
            end else if (bus.bdREN || bus.bdWEN) begin
               state_d = DATA;
            end else if (|bus.iREN) begin
               state_d = INSTR;
               g_d     = pick;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         g_q          <= 1'b0;
         rr_ptr_q     <= 1'b0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         g_q          <= g_d;
         rr_ptr_q     <= rr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign bus.ramREN    = ram_ren;
   assign bus.ramWEN    = ram_wen;
   assign bus.ramaddr   = ram_addr;
   assign bus.ramstore  = ram_store;
   assign bus.mem_error = mem_err;
   assign bus.bdwait    = bd_wait;
   assign bus.bdload    = bd_load;
   assign bus.iwait     = i_wait;
   assign bus.iload     = i_load;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int unsigned AW    = 32;
   localparam int unsigned LIMIT = 4;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.master)
   );

   always #5 CLK = ~CLK;

   // Inputs change 1 time unit after the rising edge; outputs are sampled 3 later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.bdREN    = 1'b0;
      bus.bdWEN    = 1'b0;
      bus.bdaddr   = '0;
      bus.bdstore  = '0;
      bus.iREN     = 2'b00;
      bus.iaddr    = '0;
      bus.ramload  = '0;
      bus.ramstate = 2'd0;
   endtask

   task automatic test_reset();
      clear_inputs();
      bus.bdWEN    = 1'b1;
      bus.iREN     = 2'b11;
      bus.ramstate = 2'd2;
      nRST = 1'b0;
      #2;
      n_checks++;
      if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
         n_fail++; $display("FAIL reset_ram_en got=%b%b want=00", bus.ramREN, bus.ramWEN);
      end
      n_checks++;
      if (bus.ramaddr !== '0 || bus.ramstore !== '0) begin
         n_fail++; $display("FAIL reset_ram_bus got=%h/%h want=0/0", bus.ramaddr, bus.ramstore);
      end
      n_checks++;
      if (bus.bdwait !== 1'b1 || bus.iwait !== 2'b11) begin
         n_fail++; $display("FAIL reset_waits got=%b/%b want=1/11", bus.bdwait, bus.iwait);
      end
      n_checks++;
      if (bus.bdload !== '0 || bus.iload !== '0 || bus.mem_error !== 1'b0) begin
         n_fail++; $display("FAIL reset_loads got=%h/%h/%b want=0/0/0",
                            bus.bdload, bus.iload, bus.mem_error);
      end
      tick();
      tick();
      clear_inputs();
      nRST = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch();
      bus.iREN     = 2'b01;
      bus.iaddr[0] = 32'h40;
      #3;
      n_checks++;
      if (bus.ramREN !== 1'b0 || bus.iwait !== 2'b11) begin
         n_fail++; $display("FAIL fetch_idle got=%b/%b want=0/11", bus.ramREN, bus.iwait);
      end
      tick();
      bus.ramstate = 2'd2;
      bus.ramload  = 32'hDEADBEEF;
      #3;
      n_checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin
         n_fail++; $display("FAIL fetch_cmd got=%b/%h want=1/40", bus.ramREN, bus.ramaddr);
      end
      n_checks++;
      if (bus.iwait !== 2'b10 || bus.iload[0] !== 32'hDEADBEEF || bus.iload[1] !== '0) begin
         n_fail++; $display("FAIL fetch_done got=%b/%h/%h want=10/deadbeef/0",
                            bus.iwait, bus.iload[0], bus.iload[1]);
      end
      tick();
      clear_inputs();
      #3;
      n_checks++;
      if (bus.iwait !== 2'b11 || bus.ramREN !== 1'b0) begin
         n_fail++; $display("FAIL fetch_after got=%b/%b want=11/0", bus.iwait, bus.ramREN);
      end
      tick();
   endtask

   task automatic test_collision();
      bus.bdWEN    = 1'b1;
      bus.bdaddr   = 32'h100;
      bus.bdstore  = 32'h5;
      bus.iREN     = 2'b10;
      bus.iaddr[1] = 32'h200;
      tick();
      for (int k = 0; k < 3; k++) begin
         bus.ramstate = (k == 2) ? 2'd2 : 2'd1;
         #3;
         n_checks++;
         if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h100 ||
             bus.ramstore !== 32'h5) begin
            n_fail++; $display("FAIL collide_cmd%0d got=%b%b/%h/%h want=10/100/5", k,
                               bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
         end
         n_checks++;
         if (bus.bdwait !== ((k == 2) ? 1'b0 : 1'b1) || bus.iwait !== 2'b11) begin
            n_fail++; $display("FAIL collide_wait%0d got=%b/%b want=%b/11", k,
                               bus.bdwait, bus.iwait, (k == 2) ? 1'b0 : 1'b1);
         end
         tick();
      end
      bus.bdWEN = 1'b0;
      #3;
      n_checks++;
      if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0 || bus.bdwait !== 1'b1) begin
         n_fail++; $display("FAIL collide_idle got=%b%b/%b want=00/1",
                            bus.ramWEN, bus.ramREN, bus.bdwait);
      end
      tick();
      bus.ramload = 32'h1234;
      #3;
      n_checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h200 || bus.iwait !== 2'b01 ||
          bus.iload[1] !== 32'h1234) begin
         n_fail++; $display("FAIL collide_instr got=%b/%h/%b/%h want=1/200/01/1234",
                            bus.ramREN, bus.ramaddr, bus.iwait, bus.iload[1]);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_round_robin();
      int g;
      bus.iREN     = 2'b11;
      bus.iaddr[0] = 32'hA0;
      bus.iaddr[1] = 32'hB0;
      bus.ramstate = 2'd2;
      for (int k = 0; k < 8; k++) begin
         #3;
         if (k % 2 == 1) begin
            g = ((k - 1) / 2) % 2;
            n_checks++;
            if (bus.iwait !== ((g == 0) ? 2'b10 : 2'b01) ||
                bus.ramaddr !== ((g == 0) ? 32'hA0 : 32'hB0)) begin
               n_fail++; $display("FAIL rr_grant%0d got=%b/%h want core %0d", k,
                                  bus.iwait, bus.ramaddr, g);
            end
         end else begin
            n_checks++;
            if (bus.iwait !== 2'b11 || bus.ramREN !== 1'b0) begin
               n_fail++; $display("FAIL rr_idle%0d got=%b/%b want=11/0", k,
                                  bus.iwait, bus.ramREN);
            end
         end
         tick();
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_starvation();
      bit is_instr;
      bus.bdREN    = 1'b1;
      bus.bdaddr   = 32'h300;
      bus.iREN     = 2'b01;
      bus.iaddr[0] = 32'h40;
      bus.ramstate = 2'd2;
      for (int k = 0; k < 12; k++) begin
         #3;
         if (k % 2 == 1) begin
            is_instr = ((k - 1) / 2 == int'(LIMIT));
            n_checks++;
            if (bus.bdwait !== is_instr || bus.iwait !== (is_instr ? 2'b10 : 2'b11) ||
                bus.ramaddr !== (is_instr ? 32'h40 : 32'h300)) begin
               n_fail++; $display("FAIL starve_grant%0d got=%b/%b/%h want instr=%b", k,
                                  bus.bdwait, bus.iwait, bus.ramaddr, is_instr);
            end
         end else begin
            n_checks++;
            if (bus.bdwait !== 1'b1 || bus.iwait !== 2'b11 || bus.ramREN !== 1'b0) begin
               n_fail++; $display("FAIL starve_idle%0d got=%b/%b/%b want=1/11/0", k,
                                  bus.bdwait, bus.iwait, bus.ramREN);
            end
         end
         tick();
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_error();
      bus.bdREN    = 1'b1;
      bus.bdaddr   = 32'h500;
      bus.ramstate = 2'd3;
      #3;
      n_checks++;
      if (bus.mem_error !== 1'b0) begin
         n_fail++; $display("FAIL err_idle got=%b want=0", bus.mem_error);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         bus.ramstate = (k == 2) ? 2'd2 : 2'd3;
         bus.ramload  = 32'hCAFE0001;
         #3;
         n_checks++;
         if (bus.mem_error !== ((k == 2) ? 1'b0 : 1'b1) ||
             bus.bdwait !== ((k == 2) ? 1'b0 : 1'b1) || bus.ramREN !== 1'b1) begin
            n_fail++; $display("FAIL err_seq%0d got err=%b wait=%b ren=%b", k,
                               bus.mem_error, bus.bdwait, bus.ramREN);
         end
         if (k == 2) begin
            n_checks++;
            if (bus.bdload !== 32'hCAFE0001) begin
               n_fail++; $display("FAIL err_load got=%h want=cafe0001", bus.bdload);
            end
         end
         tick();
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_withdraw_and_reset();
      bus.iREN     = 2'b01;
      bus.iaddr[0] = 32'h44;
      bus.ramstate = 2'd1;
      tick();
      #3;
      n_checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44) begin
         n_fail++; $display("FAIL wd_grant got=%b/%h want=1/44", bus.ramREN, bus.ramaddr);
      end
      tick();
      bus.iREN = 2'b00;
      #3;
      n_checks++;
      if (bus.iwait !== 2'b11 || bus.ramREN !== 1'b0) begin
         n_fail++; $display("FAIL wd_drop got=%b/%b want=11/0", bus.iwait, bus.ramREN);
      end
      tick();
      bus.iREN     = 2'b10;
      bus.iaddr[1] = 32'h88;
      bus.ramstate = 2'd2;
      #3;
      n_checks++;
      if (bus.ramREN !== 1'b0 || bus.iwait !== 2'b11) begin
         n_fail++; $display("FAIL wd_idle got=%b/%b want=0/11", bus.ramREN, bus.iwait);
      end
      tick();
      #3;
      n_checks++;
      if (bus.iwait !== 2'b01 || bus.ramaddr !== 32'h88) begin
         n_fail++; $display("FAIL wd_next got=%b/%h want=01/88", bus.iwait, bus.ramaddr);
      end
      tick();
      clear_inputs();
      tick();
      // Reset in the middle of a data write.
      bus.bdWEN    = 1'b1;
      bus.bdaddr   = 32'h600;
      bus.ramstate = 2'd1;
      tick();
      #1;
      n_checks++;
      if (bus.ramWEN !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre got=%b want=1", bus.ramWEN);
      end
      nRST = 1'b0;
      #1;
      n_checks++;
      if (bus.ramWEN !== 1'b0 || bus.bdwait !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid got=%b/%b want=0/1", bus.ramWEN, bus.bdwait);
      end
      tick();
      nRST = 1'b1;
      bus.ramstate = 2'd2;
      #3;
      n_checks++;
      if (bus.ramWEN !== 1'b0 || bus.bdwait !== 1'b1) begin
         n_fail++; $display("FAIL rst_idle got=%b/%b want=0/1", bus.ramWEN, bus.bdwait);
      end
      tick();
      #3;
      n_checks++;
      if (bus.ramWEN !== 1'b1 || bus.bdwait !== 1'b0) begin
         n_fail++; $display("FAIL rst_regrant got=%b/%b want=1/0", bus.ramWEN, bus.bdwait);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   // Reference model: owner is -1 (port free), 0/1 (fetch core) or 2 (data path).
   task automatic test_random();
      int owner, rr, starve, pick;
      bit active;
      logic e_ren, e_wen, e_err, e_bdwait;
      logic [AW-1:0] e_addr, e_store, e_bdload;
      logic [1:0] e_iwait;
      logic [1:0][AW-1:0] e_iload;
      clear_inputs();
      nRST = 1'b0;
      #2;
      tick();
      nRST   = 1'b1;
      owner  = -1;
      rr     = 0;
      starve = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) bus.bdREN = ~bus.bdREN;
         if ($urandom_range(5) == 0) bus.bdWEN = ~bus.bdWEN;
         if ($urandom_range(3) == 0) bus.iREN[0] = ~bus.iREN[0];
         if ($urandom_range(3) == 0) bus.iREN[1] = ~bus.iREN[1];
         bus.bdaddr   = $urandom;
         bus.bdstore  = $urandom;
         bus.iaddr[0] = $urandom;
         bus.iaddr[1] = $urandom;
         bus.ramload  = $urandom;
         bus.ramstate = ($urandom_range(7) < 4) ? 2'd2 : 2'($urandom_range(3));

         e_ren = 0; e_wen = 0; e_err = 0; e_bdwait = 1; e_addr = '0; e_store = '0;
         e_bdload = '0; e_iwait = 2'b11; e_iload = '0;
         active = 0;
         if (owner == 2) begin
            active = bus.bdREN || bus.bdWEN;
            if (active) begin
               e_wen   = bus.bdWEN;
               e_ren   = bus.bdREN && !bus.bdWEN;
               e_addr  = bus.bdaddr;
               e_store = bus.bdstore;
               e_err   = (bus.ramstate == 2'd3);
               if (bus.ramstate == 2'd2) begin
                  e_bdwait = 0;
                  e_bdload = bus.ramload;
               end
            end
         end else if (owner >= 0) begin
            active = bus.iREN[owner];
            if (active) begin
               e_ren  = 1;
               e_addr = bus.iaddr[owner];
               e_err  = (bus.ramstate == 2'd3);
               if (bus.ramstate == 2'd2) begin
                  e_iwait[owner] = 0;
                  e_iload[owner] = bus.ramload;
               end
            end
         end
         #3;
         n_checks++;
         if (bus.ramREN !== e_ren || bus.ramWEN !== e_wen || bus.mem_error !== e_err) begin
            n_fail++; $display("FAIL rnd_ctl c=%0d got=%b%b%b want=%b%b%b", c, bus.ramREN,
                               bus.ramWEN, bus.mem_error, e_ren, e_wen, e_err);
         end
         n_checks++;
         if (bus.ramaddr !== e_addr || bus.ramstore !== e_store) begin
            n_fail++; $display("FAIL rnd_bus c=%0d got=%h/%h want=%h/%h", c, bus.ramaddr,
                               bus.ramstore, e_addr, e_store);
         end
         n_checks++;
         if (bus.bdwait !== e_bdwait || bus.bdload !== e_bdload) begin
            n_fail++; $display("FAIL rnd_data c=%0d got=%b/%h want=%b/%h", c, bus.bdwait,
                               bus.bdload, e_bdwait, e_bdload);
         end
         n_checks++;
         if (bus.iwait !== e_iwait || bus.iload !== e_iload) begin
            n_fail++; $display("FAIL rnd_instr c=%0d got=%b/%h want=%b/%h", c, bus.iwait,
                               bus.iload, e_iwait, e_iload);
         end

         pick = (bus.iREN == 2'b11) ? rr : ((bus.iREN == 2'b10) ? 1 : 0);
         if (owner == -1) begin
            if (starve == int'(LIMIT) && bus.iREN != 2'b00) owner = pick;
            else if (bus.bdREN || bus.bdWEN)               owner = 2;
            else if (bus.iREN != 2'b00)                    owner = pick;
            if (bus.iREN == 2'b00) starve = 0;
         end else if (!active) begin
            owner = -1;
         end else if (bus.ramstate == 2'd2) begin
            if (owner == 2) begin
               if (bus.iREN != 2'b00 && starve < int'(LIMIT)) starve++;
            end else begin
               rr     = 1 - owner;
               starve = 0;
            end
            owner = -1;
         end
         tick();
      end
      clear_inputs();
      tick();
   endtask

   initial begin
      clear_inputs();
      #1;
      test_reset();
      test_single_fetch();
      test_collision();
      test_round_robin();
      test_starvation();
      test_error();
      test_withdraw_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
